// File: rtl/router_fsm.sv
// router_fsm: packet-level controller of the 1x3 router.
// It decodes the header address and sequences the header, payload and parity loads into router_register.
// It also drives write_enb_reg and busy for the FIFO write path and the packet source.
module router_fsm #(
    parameter int NUM_PORTS = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_fsm_next;
    state_t      w_next_state;
    logic [1:0]  r_addr;
    logic        w_addr_ok;
    logic [3:0]  w_empty_v;
    logic [3:0]  w_soft_v;

    // Port-indexed views; bit 3 (address 3) is tied low, so indexing by any 2-bit address is in range.
    assign w_empty_v = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign w_soft_v  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign w_addr_ok = ({30'd0, data_in} < 32'(NUM_PORTS));

    // State register with asynchronous return to address decode.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Destination address capture; it selects the empty and soft-reset lines for the whole packet.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr <= 2'b00;
        end else if ((r_state == DECODE_ADDRESS) && pkt_valid) begin
            r_addr <= data_in;
        end else begin
            r_addr <= r_addr;
        end
    end

    // Normal packet sequencing, ignoring soft reset.
    always_comb begin
        w_fsm_next = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                if (pkt_valid && w_addr_ok) begin
                    if (w_empty_v[data_in]) begin
                        w_fsm_next = LOAD_FIRST_DATA;
                    end else begin
                        w_fsm_next = WAIT_TILL_EMPTY;
                    end
                end else begin
                    w_fsm_next = DECODE_ADDRESS;
                end
            end
            LOAD_FIRST_DATA: w_fsm_next = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    w_fsm_next = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    w_fsm_next = LOAD_PARITY;
                end else begin
                    w_fsm_next = LOAD_DATA;
                end
            end
            FIFO_FULL_STATE: begin
                if (fifo_full) begin
                    w_fsm_next = FIFO_FULL_STATE;
                end else begin
                    w_fsm_next = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    w_fsm_next = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    w_fsm_next = LOAD_PARITY;
                end else begin
                    w_fsm_next = LOAD_DATA;
                end
            end
            LOAD_PARITY: w_fsm_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                if (fifo_full) begin
                    w_fsm_next = FIFO_FULL_STATE;
                end else begin
                    w_fsm_next = DECODE_ADDRESS;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (w_empty_v[r_addr]) begin
                    w_fsm_next = LOAD_FIRST_DATA;
                end else begin
                    w_fsm_next = WAIT_TILL_EMPTY;
                end
            end
            default: w_fsm_next = DECODE_ADDRESS;
        endcase
    end

    // A soft reset of the selected port aborts the packet from any state except address decode.
    always_comb begin
        w_next_state = w_fsm_next;
        if ((r_state != DECODE_ADDRESS) && w_soft_v[r_addr]) begin
            w_next_state = DECODE_ADDRESS;
        end else begin
            w_next_state = w_fsm_next;
        end
    end

    // Moore output decode from the current state only.
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b1;
        case (r_state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            LOAD_FIRST_DATA: lfd_state = 1'b1;
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE:    full_state    = 1'b1;
            LOAD_PARITY:        write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR: rst_int_reg   = 1'b1;
            WAIT_TILL_EMPTY:    busy          = 1'b1;
            default: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed testbench for router_fsm: packet flows, full/after-full paths, invalid address, soft and async reset.
module tb_router_fsm;

    logic clock;
    logic resetn;
    logic pkt_valid;
    logic [1:0] data_in;
    logic fifo_full;
    logic fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic soft_reset_0, soft_reset_1, soft_reset_2;
    logic parity_done, low_pkt_valid;
    logic detect_add, lfd_state, ld_state, laf_state, full_state;
    logic rst_int_reg, write_enb_reg, busy;

    int n_total;
    int n_pass;
    int n_web;
    int n_rst;

    // Expected output vector per state:
    // {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy}
    localparam logic [7:0] V_DA   = 8'b1000_0000;
    localparam logic [7:0] V_LFD  = 8'b0100_0001;
    localparam logic [7:0] V_LD   = 8'b0010_0010;
    localparam logic [7:0] V_LAF  = 8'b0001_0011;
    localparam logic [7:0] V_FULL = 8'b0000_1001;
    localparam logic [7:0] V_LP   = 8'b0000_0011;
    localparam logic [7:0] V_CPE  = 8'b0000_0101;
    localparam logic [7:0] V_WTE  = 8'b0000_0001;

    router_fsm #(.NUM_PORTS(3)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, busy};
    endfunction

    // Advance one clock, sample 1 time unit later, check the output vector and tally pulses.
    task automatic step_chk(input string tag, input logic [7:0] exp);
        @(posedge clock);
        #1;
        chk(tag, {24'd0, outs()}, {24'd0, exp});
        if (write_enb_reg === 1'b1) n_web++;
        if (rst_int_reg === 1'b1) n_rst++;
    endtask

    initial begin
        n_total = 0; n_pass = 0; n_web = 0; n_rst = 0;
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
        fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        // Reset state
        #3;
        chk("reset_outputs", {24'd0, outs()}, {24'd0, V_DA});
        @(posedge clock);
        #3 resetn = 1'b1;
        step_chk("idle_no_valid", V_DA);

        // Good packet to port 2: header, 8 payload bytes, parity
        pkt_valid = 1'b1; data_in = 2'b10; fifo_empty_2 = 1'b1;
        n_web = 0; n_rst = 0;
        step_chk("t2_lfd", V_LFD);
        for (int i = 0; i < 8; i++) step_chk("t2_ld", V_LD);
        pkt_valid = 1'b0;
        step_chk("t2_lp", V_LP);
        step_chk("t2_cpe", V_CPE);
        step_chk("t2_da", V_DA);
        chk("t2_web_cycles", n_web, 32'd9);
        chk("t2_rst_int_cycles", n_rst, 32'd1);

        // Busy destination FIFO 1: wait 5 cycles, then load
        pkt_valid = 1'b1; data_in = 2'b01; fifo_empty_1 = 1'b0;
        for (int i = 0; i < 5; i++) step_chk("t3_wte", V_WTE);
        fifo_empty_1 = 1'b1;
        step_chk("t3_lfd", V_LFD);
        step_chk("t3_ld", V_LD);
        pkt_valid = 1'b0;
        step_chk("t3_lp", V_LP);
        step_chk("t3_cpe", V_CPE);
        step_chk("t3_da", V_DA);

        // FIFO full mid-payload on port 0, then all after-full exits
        pkt_valid = 1'b1; data_in = 2'b00; fifo_empty_0 = 1'b1;
        step_chk("t4_lfd", V_LFD);
        step_chk("t4_ld1", V_LD);
        step_chk("t4_ld2", V_LD);
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) step_chk("t4_full", V_FULL);
        fifo_full = 1'b0;
        step_chk("t4_laf", V_LAF);
        step_chk("t4_laf_to_ld", V_LD);
        fifo_full = 1'b1; pkt_valid = 1'b0;
        step_chk("t4_full_priority", V_FULL);
        fifo_full = 1'b0;
        step_chk("t4_laf2", V_LAF);
        low_pkt_valid = 1'b1;
        step_chk("t4_laf_to_lp", V_LP);
        low_pkt_valid = 1'b0;
        step_chk("t4_cpe", V_CPE);
        fifo_full = 1'b1;
        step_chk("t4_cpe_to_full", V_FULL);
        fifo_full = 1'b0;
        step_chk("t4_laf3", V_LAF);
        parity_done = 1'b1; low_pkt_valid = 1'b1;
        step_chk("t4_laf_to_da", V_DA);
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        // Invalid address 3 stays in decode
        pkt_valid = 1'b1; data_in = 2'b11;
        step_chk("t5_stay1", V_DA);
        step_chk("t5_stay2", V_DA);

        // Soft reset: only the selected port's line aborts
        data_in = 2'b00; fifo_empty_0 = 1'b1;
        step_chk("t6_lfd", V_LFD);
        step_chk("t6_ld", V_LD);
        soft_reset_1 = 1'b1;
        step_chk("t6_other_port_ignored", V_LD);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        step_chk("t6_soft_reset", V_DA);
        soft_reset_0 = 1'b0; pkt_valid = 1'b0;
        step_chk("t6_idle", V_DA);

        // Async reset in the middle of LOAD_DATA
        pkt_valid = 1'b1; data_in = 2'b10;
        step_chk("t1_lfd", V_LFD);
        step_chk("t1_ld", V_LD);
        resetn = 1'b0;
        #2;
        chk("t1_async_detect_add", {31'd0, detect_add}, 32'd1);
        chk("t1_async_busy", {31'd0, busy}, 32'd0);
        chk("t1_async_web", {31'd0, write_enb_reg}, 32'd0);
        step_chk("t1_held_reset", V_DA);
        #2 resetn = 1'b1; pkt_valid = 1'b0;
        step_chk("t1_after_release", V_DA);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
